// File: rtl/axi_bram.sv
// ============================================================================
// Module   : axi_bram
// Brief    : AXI4-Lite slave over a single-port word RAM, one transaction at a
//            time. Define AXI_BRAM_SLVERR_EN to range-check addresses (SLVERR).
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_bram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536
) (
    input  logic              s_aclk,
    input  logic              s_aresetn,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_rready,
    input  logic              s_axi_rvalid,
    output logic [1:0]        s_axi_rresp,
    output logic [DATA_W-1:0] s_axi_rdata
);

    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_w_data = 3'd1;
    localparam logic [2:0] c_w_resp = 3'd2;
    localparam logic [2:0] c_r_data = 3'd3;

    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    logic [2:0]        r_ram_ps;
    logic [2:0]        w_ram_ns;
    logic              r_run;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [1:0]        r_bresp;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_wr_err;
    logic w_rd_err;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;

    assign w_aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_w_hs   = s_axi_wvalid  & s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
    assign w_wr_idx = r_awaddr[c_idx_w-1:0];
    assign w_rd_idx = s_axi_araddr[c_idx_w-1:0];

`ifdef AXI_BRAM_SLVERR_EN
    localparam logic [ADDR_W:0] c_depth_lim = (ADDR_W+1)'(DEPTH);
    assign w_wr_err = ({1'b0, r_awaddr}     >= c_depth_lim);
    assign w_rd_err = ({1'b0, s_axi_araddr} >= c_depth_lim);
`else
    assign w_wr_err = 1'b0;
    assign w_rd_err = 1'b0;
`endif

    // r_run keeps every ready/valid low until the first edge after reset release.
    always_ff @(posedge s_aclk or posedge s_aresetn) begin
        if (s_aresetn) begin
            r_ram_ps <= c_idle;
            r_run    <= 1'b0;
        end else begin
            r_ram_ps <= w_ram_ns;
            r_run    <= 1'b1;
        end
    end

    always_comb begin
        w_ram_ns = r_ram_ps;
        case (r_ram_ps)
            c_idle: begin
                if (w_aw_hs)      w_ram_ns = c_w_data;
                else if (w_ar_hs) w_ram_ns = c_r_data;
            end
            c_w_data: if (w_w_hs)        w_ram_ns = c_w_resp;
            c_w_resp: if (s_axi_bready)  w_ram_ns = c_idle;
            c_r_data: if (s_axi_rvalid)  w_ram_ns = c_idle;
            default:                     w_ram_ns = c_idle;
        endcase
    end

    // A pending write takes priority, so arready drops while awvalid is up.
    always_comb begin
        s_axi_awready = r_run & (r_ram_ps == c_idle);
        s_axi_arready = r_run & (r_ram_ps == c_idle) & ~s_axi_awvalid;
        s_axi_wready  = r_run & (r_ram_ps == c_w_data);
        s_axi_bvalid  = r_run & (r_ram_ps == c_w_resp);
        s_axi_rready  = r_run & (r_ram_ps == c_r_data);
        s_axi_bresp   = r_bresp;
        s_axi_rresp   = r_rresp;
        s_axi_rdata   = r_rdata;
    end

    always_ff @(posedge s_aclk or posedge s_aresetn) begin
        if (s_aresetn) begin
            r_awaddr <= '0;
            r_rdata  <= '0;
            r_rresp  <= c_okay;
            r_bresp  <= c_okay;
        end else begin
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs)  r_bresp  <= w_wr_err ? c_slverr : c_okay;
            if (w_ar_hs) begin
                r_rdata <= w_rd_err ? '0 : r_mem[w_rd_idx];
                r_rresp <= w_rd_err ? c_slverr : c_okay;
            end
        end
    end

    // RAM contents survive reset; an asserted reset forces IDLE so wready is low.
    always_ff @(posedge s_aclk) begin
        if (w_w_hs && !w_wr_err) r_mem[w_wr_idx] <= s_axi_wdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_bram.sv
// ============================================================================
// Module   : tb_axi_bram
// Brief    : Directed self-checking bench for axi_bram (AXI_BRAM_SLVERR_EN
//            selects a DEPTH=256 build with out-of-range checks).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_bram;

`ifdef AXI_BRAM_SLVERR_EN
    localparam int          c_depth = 256;
    localparam logic [15:0] c_addr_b = 16'h000F;
`else
    localparam int          c_depth = 65536;
    localparam logic [15:0] c_addr_b = 16'hAA0F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [15:0] awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [15:0] araddr = '0;
    logic        rready, rvalid = 1'b0;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_bram #(.ADDR_W(16), .DATA_W(32), .DEPTH(c_depth)) u_dut (
        .s_aclk(clk), .s_aresetn(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rready(rready), .s_axi_rvalid(rvalid), .s_axi_rresp(rresp),
        .s_axi_rdata(rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                            input int bdelay, input logic [1:0] exp_resp);
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = a;
        @(negedge clk);
        for (int i = 0; i < 20 && !awready; i++) @(negedge clk);
        check("aw_ready", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; wdata = d;
        @(negedge clk);
        check("w_ready_next", {31'd0, wready}, 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        check("b_valid", {31'd0, bvalid}, 32'd1);
        check("b_resp", {30'd0, bresp}, {30'd0, exp_resp});
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("b_valid_held", {30'd0, bvalid, awready}, 32'd2);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("b_done_idle", {30'd0, bvalid, awready}, 32'd1);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] exp,
                           input int rdelay, input logic [1:0] exp_resp);
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a;
        @(negedge clk);
        for (int i = 0; i < 20 && !arready; i++) @(negedge clk);
        check("ar_ready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("r_valid_next", {31'd0, rready}, 32'd1);
        check("r_data", rdata, exp);
        check("r_resp", {30'd0, rresp}, {30'd0, exp_resp});
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("r_held", {31'd0, rready}, 32'd1);
            check("r_data_held", rdata, exp);
        end
        rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        check("r_done_idle", {29'd0, rready, awready, arready}, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readies", {27'd0, awready, arready, wready, bvalid, rready}, 32'd0);
        check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_readies", {30'd0, awready, arready}, 32'd3);

        do_write(16'h0001, 32'h0000000A, 0, 2'b00);
        do_read(16'h0001, 32'h0000000A, 0, 2'b00);

        do_write(c_addr_b, 32'h110A0FB9, 5, 2'b00);
        do_read(c_addr_b, 32'h110A0FB9, 10, 2'b00);

        // Simultaneous aw/ar: write must complete before the read is taken.
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = 16'h0002; arvalid = 1'b1; araddr = 16'h0002;
        @(negedge clk);
        check("both_rdy", {30'd0, awready, arready}, 32'd2);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h00000005;
        @(negedge clk);
        check("both_wdata", {30'd0, wready, arready}, 32'd2);
        @(posedge clk); #1;
        wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        check("both_bvalid", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("both_ar_now", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("both_rvalid", {31'd0, rready}, 32'd1);
        check("both_rdata", rdata, 32'h00000005);
        rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;

        // Reset while in W_DATA aborts the write.
        do_write(16'h0003, 32'h00000033, 0, 2'b00);
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = 16'h0003;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("abort_in_wdata", {31'd0, wready}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_outputs", {27'd0, awready, arready, wready, bvalid, rready}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        wvalid = 1'b0; rst = 1'b0;
        @(posedge clk);
        do_read(16'h0003, 32'h00000033, 0, 2'b00);

`ifdef AXI_BRAM_SLVERR_EN
        do_write(16'h0000, 32'h12345678, 0, 2'b00);
        do_write(16'h0100, 32'hBADBAD00, 0, 2'b10);
        do_read(16'h0000, 32'h12345678, 0, 2'b00);
        do_read(16'h0100, 32'h00000000, 0, 2'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
